mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Parametrised multi-cycle MIPS control unit, successor to the fixed-latency controller: same datapath mux encodings, plus variable-latency memory handshake, a wait watchdog, bne/addi, and a sticky halt on fault. Drives the multi-cycle datapath and handshakes with the instruction/data memory port. Decodes op/funct and sequences one instruction at a time.

## Interface
- WAIT_W, 4: wait-counter width; watchdog fires after 2^WAIT_W-1 consecutive stalled cycles
- STATE_W, 4: width of state register and dbg_state port (minimum 4)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26] from instruction register
- funct  in  6  instruction[5:0]
- zero  in  1  ALU result zero flag
- mem_ready  in  1  memory completed current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- iord  out  1  address select: 0 PC, 1 ALUOut
- ir_we  out  1  instruction register load
- pc_en  out  1  PC load
- reg_we  out  1  register file write
- reg_dst  out  2  00 rt, 01 rd, 10 r31
- wd_sel  out  2  00 ALUOut, 01 memory data, 10 PC
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 constant 4, 10 sign-ext imm, 11 imm<<2
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- dbg_state  out  STATE_W  current state code
- illegal  out  1  sticky: unsupported op/funct decoded
- timeout  out  1  sticky: watchdog fired

## Operation
- States (code): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JAL 12, JR 13, HALT 15.
- FETCH: mem_req=1, iord=0, src_a=0, src_b=01, alu add, pc_src=00; ir_we=pc_en=1 only in the cycle mem_ready=1, then -> DECODE; else stay.
- DECODE: src_a=0, src_b=11, alu add (branch target into ALUOut). Dispatch: op 000000 -> EXEC (funct 001000 -> JR); 100011/101011 -> MEMADR; 000100/000101 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; 000011 -> JAL; else HALT, illegal=1.
- EXEC: src_a=1, src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; other funct -> HALT, illegal=1) -> ALUWB: reg_dst=01, wd_sel=00, reg_we=1 -> FETCH.
- MEMADR: src_a=1, src_b=10, add -> MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB: reg_dst=00, wd_sel=01, reg_we=1 -> FETCH.
- MEMWR: mem_req=mem_we=1, iord=1; on mem_ready -> FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01; pc_en=zero (beq) or !zero (bne) -> FETCH.
- ADDIEX: src_a=1, src_b=10, add -> ADDIWB: reg_dst=00, wd_sel=00, reg_we=1 -> FETCH.
- JUMP: pc_src=10, pc_en=1 -> FETCH. JAL: additionally reg_dst=10, wd_sel=10, reg_we=1. JR: pc_src=11, pc_en=1.
- Unlisted outputs are 0 in every state. HALT: all enables/req 0; held until reset.
- Watchdog: counter increments each cycle mem_req=1 && mem_ready=0, clears on mem_ready or leaving a memory state; at 2^WAIT_W-1 -> HALT, timeout=1, no ir_we/pc_en/reg_we issued.

## Timing
- Outputs combinational from state, op/funct, zero, mem_ready; state, counter, flags registered on clk rising edge.
- Reset: state=FETCH, counter=0, illegal=timeout=0; while reset=1 all enables and mem_req forced 0, selects 0, alu_ctrl=010, dbg_state=0. Reset mid-instruction aborts it; no partial writes after deassertion.
- Zero-wait latency: R-type 4, lw 5, sw 4, beq/bne 3, addi 4, j/jal/jr 3 cycles; each memory state extends by its wait cycles.
- mem_ready ignored outside FETCH/MEMRD/MEMWR. mem_ready in the same cycle the counter reaches its limit completes the access (no timeout).

## Configuration
- MIPS_MC_JAL_EN defined: JAL and JR states present as above.
- Not defined: op 000011 and R-type funct 001000 decode as illegal -> HALT, illegal=1; states 12/13 unreachable.

## Test plan
- lw with mem_ready held low 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total, single ir_we and single pc_en pulse, reg_we in MEMWB with wd_sel=01.
- beq zero=1 and bne zero=1 -> pc_en=1 with pc_src=01 for beq, pc_en=0 for bne; both back to FETCH after 3 cycles.
- add, sub, and, or, slt -> alu_ctrl 010,110,000,001,111 in EXEC; reg_dst=01 in ALUWB.
- op 111111 -> dbg_state=15, illegal=1, no enables afterwards until reset; reset clears illegal.
- WAIT_W=4, mem_ready never asserted -> timeout=1 after 15 stalled cycles, HALT.
- jal with MIPS_MC_JAL_EN -> reg_dst=10, wd_sel=10, reg_we=1, pc_src=10; without macro -> HALT, illegal=1.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM with a variable-latency memory handshake, a stall watchdog
// and a sticky halt on fault. Defining MIPS_MC_JAL_EN enables the JAL and JR states.
module mips_mc_controller #(
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_en,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_ctrl,
    output logic [STATE_W-1:0] dbg_state,
    output logic               illegal,
    output logic               timeout
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StJal    = 4'd12,
        StJr     = 4'd13,
        StHalt   = 4'd15
    } state_e;

    localparam logic [WAIT_W-1:0] WaitOne  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WaitMax  = '1;
    localparam logic [WAIT_W-1:0] WaitLast = WaitMax - WaitOne;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_en     = 1'b0;
        reg_we    = 1'b0;
        reg_dst   = 2'b00;
        wd_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        pc_src    = 2'b00;
        alu_ctrl  = 3'b000;

        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = 3'b010;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = 2'b11;
                alu_ctrl  = 3'b010;
                case (op)
                    6'b000000: begin
                        if (funct == 6'b001000) begin
`ifdef MIPS_MC_JAL_EN
                            state_d = StJr;
`else
                            state_d   = StHalt;
                            illegal_d = 1'b1;
`endif
                        end else begin
                            state_d = StExec;
                        end
                    end
                    6'b100011, 6'b101011: state_d = StMemAdr;
                    6'b000100, 6'b000101: state_d = StBranch;
                    6'b001000:            state_d = StAddiEx;
                    6'b000010:            state_d = StJump;
`ifdef MIPS_MC_JAL_EN
                    6'b000011:            state_d = StJal;
`endif
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = 3'b010;
                state_d   = (op == 6'b101011) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                wd_sel  = 2'b01;
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StMemWr: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StExec: begin
                alu_src_a = 1'b1;
                state_d   = StAluWb;
                case (funct)
                    6'b100000: alu_ctrl = 3'b010;
                    6'b100010: alu_ctrl = 3'b110;
                    6'b100100: alu_ctrl = 3'b000;
                    6'b100101: alu_ctrl = 3'b001;
                    6'b101010: alu_ctrl = 3'b111;
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StAluWb: begin
                reg_dst = 2'b01;
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 3'b110;
                pc_src    = 2'b01;
                // op[0] distinguishes bne from beq
                pc_en     = op[0] ? ~zero : zero;
                state_d   = StFetch;
            end
            StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = 3'b010;
                state_d   = StAddiWb;
            end
            StAddiWb: begin
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StJump: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = StFetch;
            end
`ifdef MIPS_MC_JAL_EN
            StJal: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                reg_dst = 2'b10;
                wd_sel  = 2'b10;
                reg_we  = 1'b1;
                state_d = StFetch;
            end
            StJr: begin
                pc_src  = 2'b11;
                pc_en   = 1'b1;
                state_d = StFetch;
            end
`endif
            default: state_d = StHalt;
        endcase

        // Enables only fire with mem_ready, so a stall at the limit never issues a write.
        if (mem_req && !mem_ready) begin
            if (wait_q == WaitLast) begin
                state_d   = StHalt;
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + WaitOne;
            end
        end

        if (reset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            iord      = 1'b0;
            ir_we     = 1'b0;
            pc_en     = 1'b0;
            reg_we    = 1'b0;
            reg_dst   = 2'b00;
            wd_sel    = 2'b00;
            alu_src_a = 1'b0;
            alu_src_b = 2'b00;
            pc_src    = 2'b00;
            alu_ctrl  = 3'b010;
        end
    end

    assign dbg_state = reset ? '0 : STATE_W'(state_q);
    assign illegal   = illegal_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle state and output-vector checks against
// hand-derived constants, covering waits, branches, R-type decode, faults and the watchdog.
module tb_mips_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, iord, ir_we, pc_en, reg_we, alu_src_a;
    logic [1:0] reg_dst, wd_sel, alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] dbg_state;
    logic       illegal, timeout;
    logic [17:0] outs;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // Field order: req we iord ir_we pc_en reg_we reg_dst wd_sel src_a src_b pc_src alu
    localparam logic [17:0] OFetch    = 18'b1_0_0_0_0_0_00_00_0_01_00_010;
    localparam logic [17:0] OFetchRdy = 18'b1_0_0_1_1_0_00_00_0_01_00_010;
    localparam logic [17:0] ODecode   = 18'b0_0_0_0_0_0_00_00_0_11_00_010;
    localparam logic [17:0] OMemAdr   = 18'b0_0_0_0_0_0_00_00_1_10_00_010;
    localparam logic [17:0] OMemRd    = 18'b1_0_1_0_0_0_00_00_0_00_00_000;
    localparam logic [17:0] OMemWb    = 18'b0_0_0_0_0_1_00_01_0_00_00_000;
    localparam logic [17:0] OMemWr    = 18'b1_1_1_0_0_0_00_00_0_00_00_000;
    localparam logic [17:0] OExecBase = 18'b0_0_0_0_0_0_00_00_1_00_00_000;
    localparam logic [17:0] OAluWb    = 18'b0_0_0_0_0_1_01_00_0_00_00_000;
    localparam logic [17:0] OBrTaken  = 18'b0_0_0_0_1_0_00_00_1_00_01_110;
    localparam logic [17:0] OBrNot    = 18'b0_0_0_0_0_0_00_00_1_00_01_110;
    localparam logic [17:0] OAddiEx   = 18'b0_0_0_0_0_0_00_00_1_10_00_010;
    localparam logic [17:0] OAddiWb   = 18'b0_0_0_0_0_1_00_00_0_00_00_000;
    localparam logic [17:0] OJump     = 18'b0_0_0_0_1_0_00_00_0_00_10_000;
    localparam logic [17:0] OJal      = 18'b0_0_0_0_1_1_10_10_0_00_10_000;
    localparam logic [17:0] OJr       = 18'b0_0_0_0_1_0_00_00_0_00_11_000;
    localparam logic [17:0] OHalt     = 18'b0_0_0_0_0_0_00_00_0_00_00_000;
    localparam logic [17:0] OReset    = 18'b0_0_0_0_0_0_00_00_0_00_00_010;

    localparam logic [3:0] SFetch = 4'd0, SDecode = 4'd1, SMemAdr = 4'd2, SMemRd = 4'd3;
    localparam logic [3:0] SMemWb = 4'd4, SMemWr = 4'd5, SExec = 4'd6, SAluWb = 4'd7;
    localparam logic [3:0] SBranch = 4'd8, SAddiEx = 4'd9, SAddiWb = 4'd10, SJump = 4'd11;
    localparam logic [3:0] SJal = 4'd12, SJr = 4'd13, SHalt = 4'd15;

    mips_mc_controller #(
        .WAIT_W (4),
        .STATE_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .iord     (iord),
        .ir_we    (ir_we),
        .pc_en    (pc_en),
        .reg_we   (reg_we),
        .reg_dst  (reg_dst),
        .wd_sel   (wd_sel),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .pc_src   (pc_src),
        .alu_ctrl (alu_ctrl),
        .dbg_state(dbg_state),
        .illegal  (illegal),
        .timeout  (timeout)
    );

    assign outs = {mem_req, mem_we, iord, ir_we, pc_en, reg_we, reg_dst, wd_sel,
                   alu_src_a, alu_src_b, pc_src, alu_ctrl};

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
        ncyc++;
    endtask

    // Drive mem_ready for one cycle, check state and outputs mid-cycle, then advance.
    task automatic step(input string tag, input logic rdy, input logic [3:0] st,
                        input logic [17:0] exp);
        mem_ready = rdy;
        #1;
        check_eq({tag, ".state"}, 32'(dbg_state), 32'(st));
        check_eq({tag, ".outs"}, 32'(outs), 32'(exp));
        cyc();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        zero      = 1'b0;
        op        = 6'd0;
        funct     = 6'd0;
        #1;
        check_eq("rst.outs", 32'(outs), 32'(OReset));
        check_eq("rst.state", 32'(dbg_state), 32'(0));
        check_eq("rst.flags", 32'({illegal, timeout}), 32'(0));
        cyc();
        reset = 1'b0;
        ncyc  = 0;
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        // lw, 3 fetch waits and 2 read waits: 10 cycles in total
        op = 6'b100011;
        for (int i = 0; i < 3; i++) step("lw.fetch_wait", 1'b0, SFetch, OFetch);
        step("lw.fetch", 1'b1, SFetch, OFetchRdy);
        step("lw.decode", 1'b0, SDecode, ODecode);
        step("lw.memadr", 1'b0, SMemAdr, OMemAdr);
        for (int i = 0; i < 2; i++) step("lw.memrd_wait", 1'b0, SMemRd, OMemRd);
        step("lw.memrd", 1'b1, SMemRd, OMemRd);
        step("lw.memwb", 1'b0, SMemWb, OMemWb);
        check_eq("lw.cycles", 32'(ncyc), 32'(10));

        // sw, zero wait
        ncyc = 0;
        op   = 6'b101011;
        step("sw.fetch", 1'b1, SFetch, OFetchRdy);
        step("sw.decode", 1'b0, SDecode, ODecode);
        step("sw.memadr", 1'b0, SMemAdr, OMemAdr);
        step("sw.memwr", 1'b1, SMemWr, OMemWr);
        check_eq("sw.cycles", 32'(ncyc), 32'(4));

        // beq taken, bne with zero=1 not taken, bne with zero=0 taken
        zero = 1'b1;
        op   = 6'b000100;
        step("beq.fetch", 1'b1, SFetch, OFetchRdy);
        step("beq.decode", 1'b1, SDecode, ODecode);
        step("beq.branch", 1'b1, SBranch, OBrTaken);
        op = 6'b000101;
        step("bne1.fetch", 1'b1, SFetch, OFetchRdy);
        step("bne1.decode", 1'b0, SDecode, ODecode);
        step("bne1.branch", 1'b0, SBranch, OBrNot);
        zero = 1'b0;
        step("bne0.fetch", 1'b1, SFetch, OFetchRdy);
        step("bne0.decode", 1'b0, SDecode, ODecode);
        step("bne0.branch", 1'b0, SBranch, OBrTaken);

        // R-type ALU ops
        op = 6'b000000;
        begin
            logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
            logic [2:0] alu_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
            for (int i = 0; i < 5; i++) begin
                funct = fn_tab[i];
                step("rtype.fetch", 1'b1, SFetch, OFetchRdy);
                step("rtype.decode", 1'b0, SDecode, ODecode);
                step("rtype.exec", 1'b1, SExec, OExecBase | 18'(alu_tab[i]));
                step("rtype.aluwb", 1'b0, SAluWb, OAluWb);
            end
        end

        // addi and j
        op = 6'b001000;
        step("addi.fetch", 1'b1, SFetch, OFetchRdy);
        step("addi.decode", 1'b0, SDecode, ODecode);
        step("addi.ex", 1'b0, SAddiEx, OAddiEx);
        step("addi.wb", 1'b0, SAddiWb, OAddiWb);
        op = 6'b000010;
        step("j.fetch", 1'b1, SFetch, OFetchRdy);
        step("j.decode", 1'b0, SDecode, ODecode);
        step("j.jump", 1'b0, SJump, OJump);
        step("j.back", 1'b0, SFetch, OFetch);

        // jal and jr depend on the build option
        op = 6'b000011;
        step("jal.fetch", 1'b1, SFetch, OFetchRdy);
        step("jal.decode", 1'b0, SDecode, ODecode);
`ifdef MIPS_MC_JAL_EN
        step("jal.jal", 1'b0, SJal, OJal);
        op    = 6'b000000;
        funct = 6'b001000;
        step("jr.fetch", 1'b1, SFetch, OFetchRdy);
        step("jr.decode", 1'b0, SDecode, ODecode);
        step("jr.jr", 1'b0, SJr, OJr);
        step("jr.back", 1'b0, SFetch, OFetch);
`else
        step("jal.halt", 1'b1, SHalt, OHalt);
        check_eq("jal.illegal", 32'(illegal), 32'(1));
        do_reset();
        op    = 6'b000000;
        funct = 6'b001000;
        step("jr.fetch", 1'b1, SFetch, OFetchRdy);
        step("jr.decode", 1'b0, SDecode, ODecode);
        step("jr.halt", 1'b0, SHalt, OHalt);
        check_eq("jr.illegal", 32'(illegal), 32'(1));
        do_reset();
`endif

        // Unsupported op: sticky halt, mem_ready ignored, reset clears illegal
        op = 6'b111111;
        step("ill.fetch", 1'b1, SFetch, OFetchRdy);
        step("ill.decode", 1'b0, SDecode, ODecode);
        for (int i = 0; i < 3; i++) step("ill.halt", 1'b1, SHalt, OHalt);
        check_eq("ill.flags", 32'({illegal, timeout}), 32'(2'b10));
        do_reset();

        // Unsupported R-type funct
        op    = 6'b000000;
        funct = 6'b000000;
        step("badfn.fetch", 1'b1, SFetch, OFetchRdy);
        step("badfn.decode", 1'b0, SDecode, ODecode);
        step("badfn.exec", 1'b0, SExec, OExecBase);
        step("badfn.halt", 1'b1, SHalt, OHalt);
        check_eq("badfn.illegal", 32'(illegal), 32'(1));
        do_reset();

        // mem_ready on the 15th stalled cycle still completes the fetch
        op = 6'b001000;
        for (int i = 0; i < 14; i++) step("wd.near", 1'b0, SFetch, OFetch);
        step("wd.near_rdy", 1'b1, SFetch, OFetchRdy);
        step("wd.near_dec", 1'b0, SDecode, ODecode);
        check_eq("wd.near_timeout", 32'(timeout), 32'(0));
        do_reset();

        // Watchdog fires after 15 stalled cycles
        for (int i = 0; i < 15; i++) step("wd.stall", 1'b0, SFetch, OFetch);
        step("wd.halt", 1'b1, SHalt, OHalt);
        check_eq("wd.flags", 32'({illegal, timeout}), 32'(2'b01));
        do_reset();

        // Reset during MEMRD aborts the load cleanly
        op = 6'b100011;
        step("abort.fetch", 1'b1, SFetch, OFetchRdy);
        step("abort.decode", 1'b0, SDecode, ODecode);
        step("abort.memadr", 1'b0, SMemAdr, OMemAdr);
        mem_ready = 1'b1;
        reset     = 1'b1;
        #1;
        check_eq("abort.rst_outs", 32'(outs), 32'(OReset));
        check_eq("abort.rst_state", 32'(dbg_state), 32'(0));
        cyc();
        reset = 1'b0;
        step("abort.after", 1'b0, SFetch, OFetch);
        step("abort.after2", 1'b0, SFetch, OFetch);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
